rv_writeback: RTL and testbench
===============================

// Module: rv_writeback
// PURPOSE
//  Final stage of the uRV pipeline. Consumes the registered execute-stage outputs (rd, rd value,
//  load/store flags, load function, data address) and drives the register-file write port.
//  For loads: waits for data-memory completion, aligns and sign/zero-extends the data, and
//  requests a pipeline stall while the load is outstanding.
// PARAMETERS
//  BUS_TIMEOUT  255  max cycles spent in WAIT_LOAD before forced abort (only with URV_WB_BUS_TIMEOUT_EN)
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   synchronous, active-high reset
//  x_fun_i          in   3   load function (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU
//  x_load_i         in   1   valid load in stage this cycle
//  x_store_i        in   1   valid store in stage this cycle (no rd write)
//  x_rd_i           in   5   destination register
//  x_rd_value_i     in   32  ALU result for non-load writes
//  x_rd_write_i     in   1   non-load rd write request
//  x_dm_addr_i      in   32  load address (bits [1:0] used for lane select)
//  dm_data_l_i      in   32  load data from data memory
//  dm_load_done_i   in   1   load data valid this cycle
//  w_stall_req_o    out  1   stall request to execute stage (comb)
//  rf_rd_o          out  5   register-file write index
//  rf_rd_value_o    out  32  register-file write data
//  rf_rd_write_o    out  1   register-file write enable, sampled by RF at next edge
//  w_bus_error_o    out  1   load timeout pulse (present only with URV_WB_BUS_TIMEOUT_EN)
// BEHAVIOUR
//  - State machine: IDLE, WAIT_LOAD. Reset -> IDLE; all held registers cleared; w_bus_error_o=0.
//  - IDLE, x_rd_write_i=1: rf_rd_o=x_rd_i, rf_rd_value_o=x_rd_value_i, rf_rd_write_o=1 same cycle.
//  - IDLE, x_load_i=1 and dm_load_done_i=1: formatted load data written same cycle (0 extra latency).
//  - IDLE, x_load_i=1 and dm_load_done_i=0: capture x_rd_i, x_fun_i, x_dm_addr_i[1:0] into held regs;
//    go WAIT_LOAD; w_stall_req_o=1 this cycle.
//  - WAIT_LOAD: inputs x_* ignored (execute stalled); w_stall_req_o = !dm_load_done_i;
//    on dm_load_done_i: write formatted data to held rd, return to IDLE (stall drops same cycle).
//  - x_load_i and x_rd_write_i both high: load path wins; x_store_i never writes RF.
//  - rd==0: rf_rd_write_o forced 0 (x0 never written) for both load and ALU paths.
//  - Load formatting, addr a=[1:0]: B/BU byte lane a; H/HU halfword lane a[1] (a[0] ignored);
//    W full word (a ignored); B/H sign-extend, BU/HU zero-extend; other funct3 -> write 0 with rf_rd_write_o=1.
//  - rf_rd_value_o is don't-care when rf_rd_write_o=0.
//  - Reset asserted in WAIT_LOAD: pending load dropped, no RF write in reset cycle or after.
//  - dm_load_done_i with no load outstanding: ignored.
// CONFIGURATION
//  URV_WB_BUS_TIMEOUT_EN defined: 8-bit-min counter cleared on entering WAIT_LOAD, increments each
//   WAIT_LOAD cycle; on reaching BUS_TIMEOUT without done: abort to IDLE, no RF write,
//   w_bus_error_o pulses 1 cycle, stall released. done on the limit cycle wins over timeout.
//  Not defined: no counter, no w_bus_error_o port; WAIT_LOAD waits indefinitely.
// TESTING
//  ALU write: x_rd_write_i=1,rd=5,value=0x1234 -> rf write rd=5 val 0x1234 same cycle, no stall.
//  x0 guard: x_rd_write_i=1,rd=0 -> rf_rd_write_o=0; same for load to rd=0 (done=1).
//  Zero-wait LB: fun=000,addr=..3,data=0x80FF_FF_FF, done=1 -> val 0xFFFFFF80; LBU -> 0x00000080.
//  Wait-state LHU: fun=101,addr=..2,rd=7, done low 3 cycles then data=0xBEEF0000 -> stall high
//   exactly 3 cycles, then rd=7 val 0x0000BEEF, state IDLE.
//  Reset mid-WAIT_LOAD: load pending, rst_i=1 1 cycle, then done=1 -> no RF write, stall 0.
//  Timeout (macro on, BUS_TIMEOUT=4): load, done never -> stall 4 cycles, w_bus_error_o 1-cycle
//   pulse, no RF write; repeat with done on 4th cycle -> write occurs, no error.

Source files
------------

// File: rtl/rv_writeback.sv
// Writeback stage: drives the register-file write port from ALU results or formatted load data.
// Latency: combinational; ALU writes and already-completed loads are written in the same cycle.
// Backpressure: w_stall_req_o holds the execute stage while a load is outstanding.
// Optional feature: define URV_WB_BUS_TIMEOUT_EN to abort loads after BUS_TIMEOUT wait cycles.
module rv_writeback #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic        w_stall_req_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o
`ifdef URV_WB_BUS_TIMEOUT_EN
    ,
    output logic        w_bus_error_o
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    localparam logic [31:0] BUS_TIMEOUT_V = 32'(BUS_TIMEOUT);

    state_t      state_q, state_d;
    logic [4:0]  held_rd_q;
    logic [2:0]  held_fun_q;
    logic [1:0]  held_a_q;
    logic        capture;
    logic        stall;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        err;

    // Stores never write the RF and only the byte-lane bits of the address matter here.
    logic unused_sink;
    assign unused_sink = ^{x_store_i, x_dm_addr_i[31:2], BUS_TIMEOUT_V[0]};

    // Select the addressed lane and extend it according to funct3; unknown funct3 yields zero.
    function automatic logic [31:0] fmt_load(input logic [2:0] fun, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = d >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? d[31:16] : d[15:0];
        case (fun)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'd0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'd0, h};
            3'b010:  fmt_load = d;
            default: fmt_load = 32'd0;
        endcase
    endfunction

`ifdef URV_WB_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(BUS_TIMEOUT + 1) > 8) ? $clog2(BUS_TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             limit;
    assign limit = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

    // Wait-cycle counter: restarts when a load begins waiting, counts every WAIT_LOAD cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_LOAD) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    // Next state, stall and RF write port; reset suppresses any write in the reset cycle.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        stall   = 1'b0;
        wr      = 1'b0;
        rd      = 5'd0;
        val     = 32'd0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (x_load_i) begin
                    if (dm_load_done_i) begin
                        wr  = 1'b1;
                        rd  = x_rd_i;
                        val = fmt_load(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i);
                    end else begin
                        capture = 1'b1;
                        stall   = 1'b1;
                        state_d = WAIT_LOAD;
                    end
                end else if (x_rd_write_i) begin
                    wr  = 1'b1;
                    rd  = x_rd_i;
                    val = x_rd_value_i;
                end
            end
            WAIT_LOAD: begin
                stall = !dm_load_done_i;
                if (dm_load_done_i) begin
                    wr      = 1'b1;
                    rd      = held_rd_q;
                    val     = fmt_load(held_fun_q, held_a_q, dm_data_l_i);
                    state_d = IDLE;
                end
`ifdef URV_WB_BUS_TIMEOUT_EN
                else if (limit) begin
                    stall   = 1'b0;
                    err     = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (rd == 5'd0) begin
            wr = 1'b0;
        end
        if (rst_i) begin
            wr      = 1'b0;
            stall   = 1'b0;
            err     = 1'b0;
            capture = 1'b0;
            state_d = IDLE;
        end
    end

    // State register and the held destination/format of an outstanding load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            held_rd_q  <= 5'd0;
            held_fun_q <= 3'd0;
            held_a_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                held_rd_q  <= x_rd_i;
                held_fun_q <= x_fun_i;
                held_a_q   <= x_dm_addr_i[1:0];
            end
        end
    end

    assign w_stall_req_o = stall;
    assign rf_rd_write_o = wr;
    assign rf_rd_o       = rd;
    assign rf_rd_value_o = val;
`ifdef URV_WB_BUS_TIMEOUT_EN
    assign w_bus_error_o = err;
`else
    logic unused_err;
    assign unused_err = err;
`endif

endmodule

// File: tb/tb_rv_writeback.sv
module tb_rv_writeback;

    localparam int TB_TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  x_fun_i = '0;
    logic        x_load_i = 1'b0;
    logic        x_store_i = 1'b0;
    logic [4:0]  x_rd_i = '0;
    logic [31:0] x_rd_value_i = '0;
    logic        x_rd_write_i = 1'b0;
    logic [31:0] x_dm_addr_i = '0;
    logic [31:0] dm_data_l_i = '0;
    logic        dm_load_done_i = 1'b0;
    logic        w_stall_req_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic        err_obs;
`ifdef URV_WB_BUS_TIMEOUT_EN
    logic        w_bus_error_o;
    assign err_obs = w_bus_error_o;
`else
    assign err_obs = 1'b0;
`endif

    rv_writeback #(.BUS_TIMEOUT(TB_TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .x_fun_i(x_fun_i), .x_load_i(x_load_i),
        .x_store_i(x_store_i), .x_rd_i(x_rd_i), .x_rd_value_i(x_rd_value_i),
        .x_rd_write_i(x_rd_write_i), .x_dm_addr_i(x_dm_addr_i), .dm_data_l_i(dm_data_l_i),
        .dm_load_done_i(dm_load_done_i), .w_stall_req_o(w_stall_req_o), .rf_rd_o(rf_rd_o),
        .rf_rd_value_o(rf_rd_value_o), .rf_rd_write_o(rf_rd_write_o)
`ifdef URV_WB_BUS_TIMEOUT_EN
        , .w_bus_error_o(w_bus_error_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        wr;
        bit [4:0]  rd;
        bit [31:0] val;
        bit        stall;
        bit        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model state: a single outstanding load and how long it has waited.
    bit       pend = 0;
    bit [4:0] p_rd;
    bit [2:0] p_fun;
    bit [1:0] p_a;
    int       p_wait;

    function automatic bit [31:0] ref_fmt(bit [2:0] fun, bit [1:0] a, bit [31:0] d);
        bit [31:0] byte_v;
        bit [31:0] half_v;
        byte_v = (d >> (8 * a)) & 32'hFF;
        half_v = (d >> (16 * a[1])) & 32'hFFFF;
        case (fun)
            3'd0: return (byte_v >= 32'h80) ? (byte_v | 32'hFFFF_FF00) : byte_v;
            3'd4: return byte_v;
            3'd1: return (half_v >= 32'h8000) ? (half_v | 32'hFFFF_0000) : half_v;
            3'd5: return half_v;
            3'd2: return d;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string name, bit [31:0] act, bit [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc_no, act, req);
        end
    endtask

    // One clock of stimulus; the model predicts the outputs and queues them for the monitor.
    task automatic cyc(bit rst, bit load, bit store, bit wr, bit [2:0] fun, bit [4:0] rd,
                       bit [31:0] val, bit [31:0] addr, bit [31:0] data, bit done);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i = rst; x_load_i = load; x_store_i = store; x_rd_write_i = wr;
        x_fun_i = fun; x_rd_i = rd; x_rd_value_i = val; x_dm_addr_i = addr;
        dm_data_l_i = data; dm_load_done_i = done;
        e = '{wr: 0, rd: 0, val: 0, stall: 0, err: 0};
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            if (done) begin
                e.wr = 1; e.rd = p_rd; e.val = ref_fmt(p_fun, p_a, data);
                pend = 0;
`ifdef URV_WB_BUS_TIMEOUT_EN
            end else if (p_wait == TB_TO - 1) begin
                e.err = 1;
                pend = 0;
`endif
            end else begin
                e.stall = 1;
                p_wait++;
            end
        end else if (load) begin
            if (done) begin
                e.wr = 1; e.rd = rd; e.val = ref_fmt(fun, addr[1:0], data);
            end else begin
                e.stall = 1;
                pend = 1; p_rd = rd; p_fun = fun; p_a = addr[1:0]; p_wait = 0;
            end
        end else if (wr) begin
            e.wr = 1; e.rd = rd; e.val = val;
        end
        if (e.rd == 0) e.wr = 0;
        exp_q.push_back(e);
    endtask

    task automatic idle(bit done);
        cyc(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, $urandom, done);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", {31'd0, w_stall_req_o}, {31'd0, e.stall});
                chk("rf_write", {31'd0, rf_rd_write_o}, {31'd0, e.wr});
                chk("bus_error", {31'd0, err_obs}, {31'd0, e.err});
                if (e.wr) begin
                    chk("rf_rd", {27'd0, rf_rd_o}, {27'd0, e.rd});
                    chk("rf_value", rf_rd_value_o, e.val);
                end
            end
        end
    end

    initial begin
        int d;
        cyc(1, 0, 0, 1, 3'd0, 5'd3, 32'h1, 32'h0, 32'h0, 1);
        cyc(1, 1, 0, 0, 3'd0, 5'd3, 32'h1, 32'h0, 32'h0, 1);
        // ALU writes, x0 guard, load to x0
        cyc(0, 0, 0, 1, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 0);
        cyc(0, 0, 0, 1, 3'd0, 5'd0, 32'hDEAD, 32'h0, 32'h0, 0);
        cyc(0, 1, 0, 0, 3'd2, 5'd0, 32'h0, 32'h0, 32'h5555_5555, 1);
        // zero-wait LB / LBU on lane 3, LW, LH lane 1, invalid funct3
        cyc(0, 1, 0, 0, 3'd0, 5'd3, 32'h0, 32'h1003, 32'h80FF_FFFF, 1);
        cyc(0, 1, 0, 0, 3'd4, 5'd4, 32'h0, 32'h1003, 32'h80FF_FFFF, 1);
        cyc(0, 1, 0, 0, 3'd2, 5'd6, 32'h0, 32'h1002, 32'hCAFE_F00D, 1);
        cyc(0, 1, 0, 0, 3'd1, 5'd8, 32'h0, 32'h1003, 32'h9ABC_1234, 1);
        cyc(0, 1, 0, 0, 3'd3, 5'd9, 32'h0, 32'h1000, 32'hFFFF_FFFF, 1);
        // load and ALU write together: load wins; store alone writes nothing
        cyc(0, 1, 0, 1, 3'd4, 5'd10, 32'h7777, 32'h1001, 32'h0000_A500, 1);
        cyc(0, 0, 1, 0, 3'd2, 5'd11, 32'h7777, 32'h1000, 32'h0, 1);
        // wait-state LHU: three stall cycles then data arrives
        cyc(0, 1, 0, 0, 3'd5, 5'd7, 32'h0, 32'h2002, 32'h0, 0);
        cyc(0, 1, 0, 1, 3'd2, 5'd12, 32'h99, 32'h0, 32'h1111_1111, 0);
        cyc(0, 0, 0, 1, 3'd0, 5'd13, 32'h98, 32'h0, 32'h2222_2222, 0);
        cyc(0, 0, 0, 1, 3'd0, 5'd14, 32'h97, 32'h0, 32'hBEEF_0000, 1);
        cyc(0, 0, 0, 1, 3'd0, 5'd15, 32'h4242, 32'h0, 32'h0, 0);
        // reset while a load waits, then a late done must not write
        cyc(0, 1, 0, 0, 3'd2, 5'd9, 32'h0, 32'h0, 32'h0, 0);
        cyc(1, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
        idle(1);
        idle(1);
`ifdef URV_WB_BUS_TIMEOUT_EN
        // timeout abort, then completion on the final allowed wait cycle
        cyc(0, 1, 0, 0, 3'd2, 5'd17, 32'h0, 32'h0, 32'h0, 0);
        repeat (TB_TO) idle(0);
        idle(0);
        cyc(0, 1, 0, 0, 3'd2, 5'd18, 32'h0, 32'h0, 32'h0, 0);
        repeat (TB_TO - 1) idle(0);
        cyc(0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h1357_9BDF, 1);
`endif
        // randomized mix; inputs during waits are junk the DUT must ignore
        for (int n = 0; n < 1500; n++) begin
            d = $urandom_range(0, 9);
            if (d < 4) begin
                d = $urandom_range(0, 5);
                cyc(0, 1, 0, $urandom_range(0, 1), 3'($urandom), 5'($urandom), $urandom,
                    $urandom, $urandom, d == 0);
                for (int k = 1; k <= d; k++)
                    cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                        3'($urandom), 5'($urandom), $urandom, $urandom, $urandom, k == d);
            end else if (d < 7) begin
                cyc(0, 0, 0, 1, 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 1));
            end else if (d == 7) begin
                cyc(0, 0, 1, 0, 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 0);
            end else if (d == 8) begin
                idle($urandom_range(0, 1));
            end else begin
                cyc($urandom_range(0, 3) == 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, $urandom, 0);
            end
        end
        idle(1);
        idle(1);
        repeat (2) @(negedge clk_i);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
